// File: rtl/cdma_pkg.sv
// Shared definitions for the CDMA receive scheduler.
//   state_e     : scheduler FSM states
//   USER_W      : user-index width for the default user count
//   clog2_min1  : $clog2 that never returns 0, so 1-entry ranges keep a 1-bit field
package cdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DECIDE = 2'd3
  } state_e;

  localparam int NUM_USERS_DEF = 2;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int USER_W = clog2_min1(NUM_USERS_DEF);

endpackage

// File: rtl/cdma_rx_scheduler_if.sv
// Decided-bit output stream, valid/ready.
//   bit_data  : decided bit (1 = positive correlation)
//   bit_user  : user index of bit_data
//   bit_valid : head entry present
//   bit_ready : consumer takes the head when valid & ready
// master = scheduler side, slave = consumer side.
interface cdma_rx_scheduler_if #(
  parameter int USER_W = cdma_pkg::USER_W
);
  logic              bit_data;
  logic [USER_W-1:0] bit_user;
  logic              bit_valid;
  logic              bit_ready;

  modport master (output bit_data, bit_user, bit_valid, input bit_ready);
  modport slave  (input bit_data, bit_user, bit_valid, output bit_ready);
endinterface

// File: rtl/cdma_bit_fifo.sv
// Small synchronous FIFO for decided bits.
//   push_i/push_data_i/full_o : write side; a push while full is ignored
//                               unless a pop happens in the same cycle
//   pop_i/pop_data_o/empty_o  : read side; pop_data_o is the head, and while
//                               empty it holds the last entry popped
// Pointers carry one extra wrap bit to tell full from empty.
module cdma_bit_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);
  localparam int AW = cdma_pkg::clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] head;
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  // When full, the write slot is the head slot; a simultaneous pop reads the
  // old head before the edge, so both can be honoured.
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;

  assign pop_data_o = empty_o ? last_q : head;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= head;
      end
    end
  end
endmodule

// File: rtl/cdma_rx_scheduler.sv
// Sequences the per-user despreading correlators one bit window at a time:
// clear, accumulate for CHIPS_PER_BIT chip ticks, then decide each user in
// turn, tracking per-user lock and queueing {user, bit} for the consumer.
//   clk, rst_n   : clock, async active-low reset
//   enable       : run windows back to back while high; low aborts a window
//   chip_tick    : chip strobe, counted only while accumulating
//   corr_acc     : signed correlator sums, user u at [u*ACC_W +: ACC_W]
//   corr_clear   : one-cycle correlator clear
//   corr_en      : accumulate enable
//   bit_if       : decided-bit stream (master)
//   user_locked  : per-user lock flags
//   overflow     : sticky, a decided bit was dropped on a full queue
module cdma_rx_scheduler
  import cdma_pkg::*;
#(
  parameter int NUM_USERS     = 2,
  parameter int CHIPS_PER_BIT = 64,
  parameter int ACC_W         = 16,
  parameter int THRESH        = 16,
  parameter int LOCK_CNT      = 3,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       chip_tick,
  input  logic [NUM_USERS*ACC_W-1:0] corr_acc,
  output logic                       corr_clear,
  output logic                       corr_en,
  cdma_rx_scheduler_if.master        bit_if,
  output logic [NUM_USERS-1:0]       user_locked,
  output logic                       overflow
);
  localparam int UW = clog2_min1(NUM_USERS);
  localparam int CW = clog2_min1(CHIPS_PER_BIT);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] LAST_CHIP = CW'(CHIPS_PER_BIT - 1);
  localparam logic [UW-1:0] LAST_USER = UW'(NUM_USERS - 1);
  localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_CNT);

  state_e                          state_q;
  logic [CW-1:0]                   chip_cnt_q;
  logic [UW-1:0]                   usr_q;
  logic [NUM_USERS-1:0][LW-1:0]    lock_cnt_q;
  logic                            corr_clear_q, corr_en_q, overflow_q;
  logic [NUM_USERS-1:0]            user_locked_q;

  logic signed [ACC_W-1:0] acc_arr [NUM_USERS];
  logic signed [ACC_W-1:0] sum;
  logic [ACC_W-1:0]        mag;
  logic                    dec_ok, dec_bit;
  logic [LW-1:0]           lock_cur, lock_d;
  logic                    push, pop, fifo_full, fifo_empty;
  logic [UW:0]             fifo_dout;

  for (genvar u = 0; u < NUM_USERS; u++) begin : g_unpack
    assign acc_arr[u] = corr_acc[u*ACC_W +: ACC_W];
  end

  // Magnitude of the user under decision; the most-negative sum has no
  // positive twin, so it saturates to the largest positive value.
  always_comb begin
    sum = acc_arr[usr_q];
    if (sum == {1'b1, {(ACC_W-1){1'b0}}}) mag = {1'b0, {(ACC_W-1){1'b1}}};
    else if (sum[ACC_W-1])                mag = ACC_W'(-sum);
    else                                  mag = ACC_W'(sum);
  end

  assign dec_ok   = (mag >= ACC_W'(THRESH));
  assign dec_bit  = ~sum[ACC_W-1] & (|sum);
  assign lock_cur = lock_cnt_q[usr_q];
  assign lock_d   = !dec_ok ? '0 :
                    (lock_cur == LOCK_MAX) ? lock_cur : lock_cur + LW'(1);

  assign push = (state_q == ST_DECIDE) && dec_ok;
  assign pop  = ~fifo_empty & bit_if.bit_ready;

  cdma_bit_fifo #(.WIDTH(UW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i({usr_q, dec_bit}),
    .full_o     (fifo_full),
    .pop_i      (pop),
    .pop_data_o (fifo_dout),
    .empty_o    (fifo_empty)
  );

  assign bit_if.bit_valid = ~fifo_empty;
  assign bit_if.bit_data  = fifo_dout[0];
  assign bit_if.bit_user  = fifo_dout[UW:1];

  assign corr_clear  = corr_clear_q;
  assign corr_en     = corr_en_q;
  assign user_locked = user_locked_q;
  assign overflow    = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      chip_cnt_q    <= '0;
      usr_q         <= '0;
      lock_cnt_q    <= '0;
      corr_clear_q  <= 1'b0;
      corr_en_q     <= 1'b0;
      user_locked_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q      <= ST_CLEAR;
            corr_clear_q <= 1'b1;
          end
        end
        ST_CLEAR: begin
          corr_clear_q <= 1'b0;
          chip_cnt_q   <= '0;
          if (!enable) begin
            state_q <= ST_IDLE;
          end else begin
            state_q   <= ST_ACCUM;
            corr_en_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          // An abort wins over a tick landing in the same cycle.
          if (!enable) begin
            state_q   <= ST_IDLE;
            corr_en_q <= 1'b0;
          end else if (chip_tick) begin
            if (chip_cnt_q == LAST_CHIP) begin
              state_q   <= ST_DECIDE;
              corr_en_q <= 1'b0;
              usr_q     <= '0;
            end else begin
              chip_cnt_q <= chip_cnt_q + CW'(1);
            end
          end
        end
        ST_DECIDE: begin
          lock_cnt_q[usr_q]    <= lock_d;
          user_locked_q[usr_q] <= (lock_d == LOCK_MAX);
          if (usr_q == LAST_USER) begin
            if (enable) begin
              state_q      <= ST_CLEAR;
              corr_clear_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            usr_q <= usr_q + UW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdma_rx_scheduler.sv
module tb_cdma_rx_scheduler;
  import cdma_pkg::*;

  localparam int NU = 2, AW = 16, CPB = 64, TH = 16, LC = 3, FD = 4;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, chip_tick = 1'b0;
  logic [NU*AW-1:0] corr_acc = '0;
  logic corr_clear, corr_en, overflow;
  logic [NU-1:0] user_locked;

  cdma_rx_scheduler_if bus ();

  cdma_rx_scheduler #(
    .NUM_USERS(NU), .CHIPS_PER_BIT(CPB), .ACC_W(AW),
    .THRESH(TH), .LOCK_CNT(LC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chip_tick(chip_tick),
    .corr_acc(corr_acc), .corr_clear(corr_clear), .corr_en(corr_en),
    .bit_if(bus), .user_locked(user_locked), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_pop = 0;
  logic [1:0] exp_q[$];       // {user, bit} in expected delivery order
  int lock_m[NU];             // consecutive valid decisions per user
  logic exp_ovf = 1'b0;
  logic [1:0] last_pop = 2'b00;
  bit rand_ready = 1'b0;

  initial bus.bit_ready = 1'b0;

  // Every accepted head is checked against the reference queue.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && bus.bit_valid && bus.bit_ready) begin
      n_tests++;
      n_pop++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got {user,bit}=%b, required no entry", {bus.bit_user, bus.bit_data});
      end else begin
        e = exp_q.pop_front();
        if ({bus.bit_user, bus.bit_data} !== e) begin
          n_fail++;
          $display("FAIL pop_order: got {user,bit}=%b, required %b", {bus.bit_user, bus.bit_data}, e);
        end
      end
      last_pop = {bus.bit_user, bus.bit_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.bit_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference decision rules for one finished window.
  task automatic model_decide(input int s0, input int s1);
    int s, m;
    for (int u = 0; u < NU; u++) begin
      s = (u == 0) ? s0 : s1;
      m = (s < 0) ? -s : s;
      if (m > 32767) m = 32767;
      if (m >= TH) begin
        if (exp_q.size() >= FD && !bus.bit_ready) exp_ovf = 1'b1;
        else exp_q.push_back({1'(u), 1'(s > 0)});
        lock_m[u] = (lock_m[u] < LC) ? lock_m[u] + 1 : LC;
      end else begin
        lock_m[u] = 0;
      end
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int u = 0; u < NU; u++) lock_m[u] = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; chip_tick = 1'b0; bus.bit_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    model_clear();
  endtask

  task automatic drain(input int n);
    bus.bit_ready = 1'b1;
    repeat (n) step();
  endtask

  // One full window; ends in the cycle after the last user's decision.
  task automatic run_window(input int s0, input int s1, input bit gaps,
                            input bit rdy_dec, input bit keep_en);
    int waited;
    logic [AW-1:0] a0, a1;
    logic [NU-1:0] el;
    a0 = s0[AW-1:0]; a1 = s1[AW-1:0];
    corr_acc = {a1, a0};
    enable = 1'b1;
    waited = 0;
    while (!corr_clear && waited < 20) begin step(); waited++; end
    n_tests++;
    if (corr_clear !== 1'b1) begin
      n_fail++; $display("FAIL win_clear: got corr_clear=%b, required 1 within 20 cycles", corr_clear);
    end
    step();
    n_tests++;
    if (corr_en !== 1'b1) begin
      n_fail++; $display("FAIL win_accum: got corr_en=%b, required 1", corr_en);
    end
    for (int t = 0; t < CPB; t++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin chip_tick = 1'b0; step(); end
      chip_tick = 1'b1;
      step();
    end
    chip_tick = 1'b0;
    if (rdy_dec) bus.bit_ready = 1'b1;
    if (!keep_en) enable = 1'b0;
    model_decide(s0, s1);
    step();
    n_tests++;
    if (user_locked[0] !== (lock_m[0] == LC)) begin
      n_fail++; $display("FAIL win_lock0: got %b, required %b", user_locked[0], lock_m[0] == LC);
    end
    step();
    for (int u = 0; u < NU; u++) el[u] = (lock_m[u] == LC);
    n_tests++;
    if (user_locked !== el) begin
      n_fail++; $display("FAIL win_lock: got %b, required %b", user_locked, el);
    end
    n_tests++;
    if (corr_clear !== keep_en) begin
      n_fail++; $display("FAIL win_next_clear: got %b, required %b", corr_clear, keep_en);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; bus.bit_ready = 1'b0;
    repeat (3) step();
    n_tests++;
    if ({corr_clear, corr_en, bus.bit_valid, overflow, user_locked, bus.bit_user, bus.bit_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got clr=%b en=%b vld=%b ovf=%b lock=%b usr=%b dat=%b, required all 0",
               corr_clear, corr_en, bus.bit_valid, overflow, user_locked, bus.bit_user, bus.bit_data);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if (corr_clear !== 1'b1) begin
      n_fail++; $display("FAIL reset_clear_pulse: got %b, required 1", corr_clear);
    end
    step();
    n_tests++;
    if ({corr_clear, corr_en} !== 2'b01) begin
      n_fail++; $display("FAIL reset_clear_one_cycle: got clr,en=%b, required 01", {corr_clear, corr_en});
    end
    enable = 1'b0;
    step();
    n_tests++;
    if (corr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_disable: got corr_en=%b, required 0", corr_en);
    end
    model_clear();
  endtask

  task automatic test_basic();
    int p0;
    p0 = n_pop;
    bus.bit_ready = 1'b1;
    run_window(40, -40, 1'b0, 1'b0, 1'b0);
    drain(6);
    n_tests++;
    if (n_pop - p0 !== 2 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL basic_count: got %0d pops (%0d pending), required 2", n_pop - p0, exp_q.size());
    end
    n_tests++;
    if ({bus.bit_valid, bus.bit_user, bus.bit_data} !== 3'b010) begin
      n_fail++; $display("FAIL basic_hold: got vld,usr,dat=%b, required 010", {bus.bit_valid, bus.bit_user, bus.bit_data});
    end
  endtask

  task automatic test_threshold();
    int p0;
    p0 = n_pop;
    bus.bit_ready = 1'b1;
    run_window(16, -16, 1'b1, 1'b0, 1'b1);
    run_window(15, 0, 1'b0, 1'b0, 1'b1);
    run_window(-32768, 16, 1'b0, 1'b0, 1'b0);
    drain(6);
    n_tests++;
    if (n_pop - p0 !== 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL thresh_count: got %0d pops (%0d pending), required 4", n_pop - p0, exp_q.size());
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.bit_ready = 1'b1;
    run_window(40, 3, 1'b0, 1'b0, 1'b1);
    run_window(-40, 3, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (user_locked[0] !== 1'b0) begin
      n_fail++; $display("FAIL lock_early: got %b after 2 windows, required 0", user_locked[0]);
    end
    run_window(40, 3, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (user_locked !== 2'b01) begin
      n_fail++; $display("FAIL lock_rise: got %b after 3 windows, required 01", user_locked);
    end
    run_window(5, 3, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (user_locked !== 2'b00) begin
      n_fail++; $display("FAIL lock_drop: got %b, required 00", user_locked);
    end
    drain(4);
  endtask

  task automatic test_overflow();
    logic [1:0] head;
    do_reset();
    run_window(40, -40, 1'b0, 1'b0, 1'b1);
    run_window(-20, 20, 1'b0, 1'b0, 1'b1);
    run_window(100, -100, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b, required 1", overflow);
    end
    head = {bus.bit_user, bus.bit_data};
    repeat (3) step();
    n_tests++;
    if ({bus.bit_valid, bus.bit_user, bus.bit_data} !== {1'b1, head}) begin
      n_fail++; $display("FAIL ovf_head_stable: got vld,head=%b, required %b", {bus.bit_valid, bus.bit_user, bus.bit_data}, {1'b1, head});
    end
    drain(8);
    n_tests++;
    if (exp_q.size() != 0 || bus.bit_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_drain: got %0d pending, vld=%b, required 0 and 0", exp_q.size(), bus.bit_valid);
    end
    // Full queue with a pop in the same cycle as each push.
    do_reset();
    run_window(40, 40, 1'b0, 1'b0, 1'b1);
    run_window(-40, -40, 1'b0, 1'b0, 1'b1);
    run_window(50, -50, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_push_pop_full: got %b, required 0", overflow);
    end
    drain(8);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL ovf_drain2: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    int waited;
    do_reset();
    bus.bit_ready = 1'b1;
    for (int w = 0; w < 3; w++) run_window(40, -40, 1'b0, 1'b0, (w < 2) ? 1'b1 : 1'b0);
    drain(4);
    corr_acc = {16'd40, 16'd40};
    enable = 1'b1;
    waited = 0;
    while (!corr_clear && waited < 20) begin step(); waited++; end
    step();
    repeat (29) begin chip_tick = 1'b1; step(); end
    chip_tick = 1'b1; enable = 1'b0;
    step();
    chip_tick = 1'b0;
    n_tests++;
    if ({corr_clear, corr_en} !== 2'b00) begin
      n_fail++; $display("FAIL abort_idle: got clr,en=%b, required 00", {corr_clear, corr_en});
    end
    repeat (40) begin chip_tick = ~chip_tick; step(); end
    chip_tick = 1'b0;
    n_tests++;
    if (bus.bit_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_no_push: got vld=%b, required 0", bus.bit_valid);
    end
    n_tests++;
    if (user_locked !== 2'b11) begin
      n_fail++; $display("FAIL abort_lock_kept: got %b, required 11", user_locked);
    end
    // Reset pulse in the middle of an accumulation with queued entries.
    bus.bit_ready = 1'b0;
    run_window(40, -40, 1'b0, 1'b0, 1'b1);
    step();
    repeat (10) begin chip_tick = 1'b1; step(); end
    chip_tick = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({corr_clear, corr_en, bus.bit_valid, overflow, user_locked, bus.bit_user, bus.bit_data} !== '0) begin
      n_fail++;
      $display("FAIL abort_reset: got clr=%b en=%b vld=%b ovf=%b lock=%b usr=%b dat=%b, required all 0",
               corr_clear, corr_en, bus.bit_valid, overflow, user_locked, bus.bit_user, bus.bit_data);
    end
    enable = 1'b0;
    model_clear();
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic int pick_sum();
    case ($urandom_range(0, 6))
      0: return TH;
      1: return -TH;
      2: return TH - 1;
      3: return -(TH - 1);
      4: return 0;
      5: return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic test_random();
    do_reset();
    rand_ready = 1'b1;
    for (int w = 0; w < 8; w++) run_window(pick_sum(), pick_sum(), 1'b1, 1'b0, (w < 7) ? 1'b1 : 1'b0);
    rand_ready = 1'b0;
    drain(8);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL random_drain: got %0d pending, required 0", exp_q.size());
    end
    n_tests++;
    if (overflow !== exp_ovf) begin
      n_fail++; $display("FAIL random_ovf: got %b, required %b", overflow, exp_ovf);
    end
  endtask

  initial begin
    for (int u = 0; u < NU; u++) lock_m[u] = 0;
    test_reset();
    test_basic();
    test_threshold();
    test_lock();
    test_overflow();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
